bit_serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor, the inverse datapath of the team's bit-serial adder. It computes `a - b` one bit per clock, LSB first. It uses a registered borrow and a single-bit full-subtractor cell. Operands are parallel-loaded on a start handshake, and a registered parallel result with a final borrow is returned with a one-cycle done pulse. It sits beside the serial adder in the arithmetic unit, so the control sequencer can issue add or subtract through the same start/done protocol.

---
 rtl/bit_serial_pkg.sv | 11 +
 rtl/full_subtractor.sv | 13 +
 rtl/bit_serial_subtractor.sv | 111 +++++++++++
 tb/tb_bit_serial_subtractor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package bit_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bss_state_t;

  localparam int BSS_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b, LSB first) with start/done handshake.
// Optional signed-overflow output enabled by BIT_SERIAL_SUBTRACTOR_OVF_EN.
module bit_serial_subtractor
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = BSS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  bss_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d;
  logic             bn;
  logic [WIDTH-1:0] sd_shift;

`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_cell (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (br),
    .d   (d),
    .bout(bn)
  );

  // The new bit enters at the top; the low bit falls off into the result on the last edge.
  assign sd_shift = {d, sd};

  // NOTE: every state element here uses <= so all flops see pre-edge values;
  // blocking assignments would let the shift registers race each other.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_shift[WIDTH-1:1];
          br  <= bn;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff  <= sd_shift;
            bout  <= bn;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed-vector bench for bit_serial_subtractor (WIDTH = 8), ovf checked when
// BIT_SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_bit_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  logic         clk;
  logic         clr_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] last_diff;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Caller is at a negedge; start is raised for the next rising edge (E0).
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
  endtask

  // Follows one operation from E0 to the done cycle; returns at the done negedge.
  task automatic wait_done(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] ediff, input logic ebout, input logic eovf,
                           input bit repulse, input bit check_idle);
    int k;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~va;
    b = ~vb;
    check({name, " busy after start"}, 32'(busy), 32'd1);
    for (k = 1; k <= W + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
      if (k == W - 1 || k == 2) begin
        check({name, " busy in run"}, 32'(busy), 32'd1);
        check({name, " diff held"}, 32'(diff), 32'(last_diff));
      end
      if (repulse && k == 3) begin
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({name, " latency"}, 32'(k), 32'(W));
    check({name, " diff"}, 32'(diff), 32'(ediff));
    check({name, " bout"}, 32'(bout), 32'(ebout));
    check({name, " busy in done"}, 32'(busy), 32'd0);
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    check({name, " ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected x in ovf expectation");
`endif
    last_diff = ediff;
    if (check_idle) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " done single"}, 32'(done), 32'd0);
      check({name, " idle after"}, 32'(busy), 32'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'd100,  8'd37,   8'd63,   1'b0, 1'b0};
    vecs[1] = '{8'd5,    8'd10,   8'd251,  1'b1, 1'b0};
    vecs[2] = '{8'd0,    8'd0,    8'd0,    1'b0, 1'b0};
    vecs[3] = '{8'd255,  8'd0,    8'd255,  1'b0, 1'b0};
    vecs[4] = '{8'd0,    8'd255,  8'd1,    1'b1, 1'b0};
    vecs[5] = '{8'h80,   8'h01,   8'h7F,   1'b0, 1'b1};
    vecs[6] = '{8'h7F,   8'hFF,   8'h80,   1'b1, 1'b1};
    vecs[7] = '{8'd3,    8'd1,    8'd2,    1'b0, 1'b0};
    vecs[8] = '{8'd200,  8'd55,   8'd145,  1'b0, 1'b0};
    vecs[9] = '{8'hAA,   8'hAA,   8'h00,   1'b0, 1'b0};

    clr_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    last_diff = '0;
    repeat (3) @(negedge clk);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    clr_n = 1'b1;
    @(negedge clk);

    // Table of directed vectors, each with an idle gap afterwards.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf, 1'b0, 1'b1);
    end

    // start re-pulsed at bit 3 with other operands must be ignored, not queued.
    launch(8'd100, 8'd37);
    wait_done("repulse", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b1, 1'b1);

    // start held in the done cycle: next op begins with no gap.
    launch(8'd5, 8'd10);
    wait_done("b2b first", 8'd5, 8'd10, 8'd251, 1'b1, 1'b0, 1'b0, 1'b0);
    launch(8'd100, 8'd37);
    wait_done("b2b second", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges while bit 4 is in flight.
    launch(8'd5, 8'd10);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("midrst diff", 32'(diff), 32'd0);
    check("midrst bout", 32'(bout), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    check("midrst ovf", 32'(ovf), 32'd0);
`endif
    last_diff = '0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("midrst no done", 32'(done), 32'd0);
    end
    launch(8'd200, 8'd55);
    wait_done("after rst", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random sweep against a (a - b) mod 256 / a < b reference.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb, rd;
      logic         rbo, rov;
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      rd  = W'((int'(ra) - int'(rb) + 256) % 256);
      rbo = (ra < rb);
      rov = ((int'($signed(ra)) - int'($signed(rb))) > 127) ||
            ((int'($signed(ra)) - int'($signed(rb))) < -128);
      launch(ra, rb);
      wait_done($sformatf("rand%0d", i), ra, rb, rd, rbo, rov, 1'b0, (i % 16) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
